// File: rtl/i2c_tx_frame_fetch_if.sv
// FIFO read port plus payload byte stream between the frame fetcher and its neighbours.
// master = the fetcher; slave = the FIFO read side and the I2C byte engine.
interface i2c_tx_frame_fetch_if #(
    parameter int DATASIZE = 8
);
    logic                rempty;
    logic [DATASIZE-1:0] rd_data;
    logic                rd_en;
    logic                m_valid;
    logic                m_ready;
    logic [DATASIZE-1:0] m_data;
    logic                m_last;

    modport master (
        input  rempty, rd_data, m_ready,
        output rd_en, m_valid, m_data, m_last
    );

    modport slave (
        output rempty, rd_data, m_ready,
        input  rd_en, m_valid, m_data, m_last
    );
endinterface

// File: rtl/i2c_tx_frame_fetch.sv
// Read-side sequencer for the AXI->I2C async FIFO: pops length-prefixed frames
// (header N, then N payload bytes) and streams the payload with a last flag.
//
// state | meaning
// IDLE  | not fetching; enable moves to HDR
// HDR   | popping the header byte (payload count N)
// DATA  | popping payload bytes and presenting them on the stream
// DRAIN | last byte captured; waiting for its handshake
module i2c_tx_frame_fetch #(
    parameter int DATASIZE = 8,
    parameter int LENSIZE  = 8
) (
    input  logic                     rd_clk,
    input  logic                     rrst_n,
    input  logic                     enable_i,
    input  logic                     abort_i,
    i2c_tx_frame_fetch_if.master     bus,
    output logic [LENSIZE-1:0]       frame_len_o,
    output logic                     busy_o,
    output logic                     zero_len_err_o
);

    typedef enum logic [1:0] {IDLE, HDR, DATA, DRAIN} state_t;

    state_t                state_q;
    logic                  pending_q;
    logic [LENSIZE-1:0]    remaining_q;
    logic [LENSIZE-1:0]    frame_len_q;
    logic                  m_valid_q;
    logic                  m_last_q;
    logic [DATASIZE-1:0]   m_data_q;
    logic                  zero_len_err_q;

    logic                  fetch_state;
    logic                  rd_en_w;
    logic                  handshake;
    logic [LENSIZE-1:0]    rd_len;

    assign fetch_state = (state_q == HDR) || (state_q == DATA);
    // A pop may coincide with the handshake that frees the output register.
    assign rd_en_w     = fetch_state && !bus.rempty && !pending_q && !abort_i &&
                         (!m_valid_q || bus.m_ready);
    assign handshake   = m_valid_q && bus.m_ready;
    assign rd_len      = LENSIZE'(bus.rd_data);

    always_ff @(posedge rd_clk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q        <= IDLE;
            pending_q      <= 1'b0;
            remaining_q    <= '0;
            frame_len_q    <= '0;
            m_valid_q      <= 1'b0;
            m_last_q       <= 1'b0;
            m_data_q       <= '0;
            zero_len_err_q <= 1'b0;
        end else begin
            zero_len_err_q <= 1'b0;
            if (abort_i) begin
                state_q     <= IDLE;
                pending_q   <= 1'b0;
                remaining_q <= '0;
                m_valid_q   <= 1'b0;
                m_last_q    <= 1'b0;
            end else begin
                pending_q <= rd_en_w;
                if (handshake) begin
                    m_valid_q <= 1'b0;
                    m_last_q  <= 1'b0;
                end
                case (state_q)
                    IDLE: begin
                        if (enable_i) state_q <= HDR;
                    end
                    HDR: begin
                        if (pending_q) begin
                            if (rd_len == '0) begin
                                zero_len_err_q <= 1'b1;
                                state_q        <= IDLE;
                            end else begin
                                frame_len_q <= rd_len;
                                remaining_q <= rd_len;
                                state_q     <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        // A capture never overlaps a handshake: the pop needed the register free.
                        if (pending_q) begin
                            m_data_q  <= bus.rd_data;
                            m_valid_q <= 1'b1;
                            m_last_q  <= (remaining_q == LENSIZE'(1));
                            if (remaining_q != '0) remaining_q <= remaining_q - LENSIZE'(1);
                            if (remaining_q <= LENSIZE'(1)) state_q <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (handshake) state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.rd_en      = rd_en_w;
    assign bus.m_valid    = m_valid_q;
    assign bus.m_data     = m_data_q;
    assign bus.m_last     = m_last_q;
    assign frame_len_o    = frame_len_q;
    assign busy_o         = (state_q != IDLE);
    assign zero_len_err_o = zero_len_err_q;

endmodule

// File: tb/tb_i2c_tx_frame_fetch.sv
// Directed bench for i2c_tx_frame_fetch: queue-based FIFO and frame model,
// per-cycle stream/handshake checker, plus literal expectations per scenario.
module tb_i2c_tx_frame_fetch;
    localparam int DW = 8;
    localparam int LW = 8;

    logic          rd_clk = 1'b0;
    logic          rrst_n = 1'b0;
    logic          enable = 1'b0;
    logic          abort  = 1'b0;
    logic [LW-1:0] frame_len;
    logic          busy;
    logic          zero_len_err;

    i2c_tx_frame_fetch_if #(.DATASIZE(DW)) bus ();

    i2c_tx_frame_fetch #(.DATASIZE(DW), .LENSIZE(LW)) dut (
        .rd_clk         (rd_clk),
        .rrst_n         (rrst_n),
        .enable_i       (enable),
        .abort_i        (abort),
        .bus            (bus),
        .frame_len_o    (frame_len),
        .busy_o         (busy),
        .zero_len_err_o (zero_len_err)
    );

    always #5 rd_clk = ~rd_clk;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } exp_t;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] fifo_q[$];
    logic [7:0] in_q[$];
    exp_t       exp_q[$];
    exp_t       e;
    logic       flush_req = 1'b0;
    int         pop_cnt   = 0;
    int         zl_cnt    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // FIFO read side: registered empty flag, read data valid the cycle after a pop.
    always @(posedge rd_clk) begin
        if (zero_len_err) zl_cnt++;
        if (bus.rd_en && fifo_q.size() != 0) begin
            bus.rd_data <= fifo_q.pop_front();
            pop_cnt++;
        end
        if (flush_req) fifo_q.delete();
        while (in_q.size() != 0) fifo_q.push_back(in_q.pop_front());
        bus.rempty <= (fifo_q.size() == 0);
    end

    // Frame model: header N, payload bytes 1..N; only the first 'present' bytes reach the stream.
    task automatic expect_frame(input logic [63:0] v, input int nbytes, input int present);
        logic [7:0] n;
        exp_t       x;
        n = v[8*(nbytes-1) +: 8];
        for (int i = 1; i <= present; i++) begin
            x.d = v[8*(nbytes-1-i) +: 8];
            x.l = (i == int'(n));
            exp_q.push_back(x);
        end
    endtask

    task automatic feed(input logic [63:0] v, input int nbytes);
        for (int i = 0; i < nbytes; i++) in_q.push_back(v[8*(nbytes-1-i) +: 8]);
    endtask

    task automatic push_frame(input logic [63:0] v, input int nbytes, input int present);
        expect_frame(v, nbytes, present);
        feed(v, nbytes);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge rd_clk);
        #1;
    endtask

    task automatic wait_last(input string name, input int bound);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge rd_clk);
            if (bus.m_valid && bus.m_ready && bus.m_last) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s timeout waiting for last handshake", name);
        end
    endtask

    task automatic wait_valid(input string name, input int bound);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge rd_clk);
            if (bus.m_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s timeout waiting for m_valid", name);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"},        {31'd0, bus.rd_en},   32'd0);
        check({tag, "_m_valid"},      {31'd0, bus.m_valid}, 32'd0);
        check({tag, "_m_last"},       {31'd0, bus.m_last},  32'd0);
        check({tag, "_m_data"},       {24'd0, bus.m_data},  32'd0);
        check({tag, "_frame_len"},    {24'd0, frame_len},   32'd0);
        check({tag, "_busy"},         {31'd0, busy},        32'd0);
        check({tag, "_zero_len_err"}, {31'd0, zero_len_err}, 32'd0);
    endtask

    // Per-cycle checker: pop legality, hold-while-stalled, and stream against the model queue.
    logic       pv = 1'b0, pr = 1'b0, pab = 1'b0, pl = 1'b0;
    logic [7:0] pd = 8'h00;
    always @(negedge rd_clk) begin
        if (!rrst_n) begin
            pv = 1'b0;
        end else begin
            if (bus.rd_en) begin
                check("rd_en_while_empty", {31'd0, bus.rempty}, 32'd0);
                check("rd_en_while_stalled", {31'd0, (bus.m_valid && !bus.m_ready)}, 32'd0);
            end
            if (pv && !pr && !pab) begin
                check("hold_valid", {31'd0, bus.m_valid}, 32'd1);
                check("hold_data",  {24'd0, bus.m_data},  {24'd0, pd});
                check("hold_last",  {31'd0, bus.m_last},  {31'd0, pl});
            end
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte actual=%0h required=no_byte", bus.m_data);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_data", {24'd0, bus.m_data}, {24'd0, e.d});
                    check("stream_last", {31'd0, bus.m_last}, {31'd0, e.l});
                end
            end
            pv  = bus.m_valid;
            pr  = bus.m_ready;
            pd  = bus.m_data;
            pl  = bus.m_last;
            pab = abort;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, z0, n;
        bus.m_ready = 1'b0;

        repeat (2) @(posedge rd_clk);
        #1;
        check_reset_outputs("reset");
        rrst_n = 1'b1;
        tick(2);

        // Basic frame; enable dropped mid-frame must not cut it short.
        push_frame(32'h03A1A2A3, 4, 3);
        bus.m_ready = 1'b1;
        p0 = pop_cnt;
        enable = 1'b1;
        wait_valid("t1_start", 40);
        tick(1);
        enable = 1'b0;
        wait_last("t1", 60);
        check("t1_last_data", {24'd0, bus.m_data}, 32'hA3);
        check("t1_busy_at_last", {31'd0, busy}, 32'd1);
        @(negedge rd_clk);
        check("t1_busy_fall", {31'd0, busy}, 32'd0);
        check("t1_pops", pop_cnt - p0, 32'd4);
        check("t1_frame_len", {24'd0, frame_len}, 32'd3);
        tick(3);

        // Zero-length header followed by a one-byte frame.
        z0 = zl_cnt;
        push_frame(8'h00, 1, 0);
        push_frame(16'h0155, 2, 1);
        enable = 1'b1;
        wait_last("t2", 60);
        check("t2_last_data", {24'd0, bus.m_data}, 32'h55);
        tick(1);
        enable = 1'b0;
        tick(3);
        check("t2_zero_len_pulses", zl_cnt - z0, 32'd1);
        check("t2_frame_len", {24'd0, frame_len}, 32'd1);

        // Backpressure: first byte held for 5 stalled cycles.
        push_frame(24'h021122, 3, 2);
        bus.m_ready = 1'b0;
        enable = 1'b1;
        wait_valid("t3", 40);
        check("t3_first_data", {24'd0, bus.m_data}, 32'h11);
        for (int i = 0; i < 5; i++) begin
            @(posedge rd_clk);
            #1;
            enable = 1'b0;
            @(negedge rd_clk);
            check("t3_stall_data", {24'd0, bus.m_data}, 32'h11);
            check("t3_stall_rd_en", {31'd0, bus.rd_en}, 32'd0);
        end
        @(posedge rd_clk);
        #1;
        bus.m_ready = 1'b1;
        wait_last("t3", 40);
        check("t3_last_data", {24'd0, bus.m_data}, 32'h22);
        tick(3);

        // Starved FIFO: second payload byte arrives 10 cycles late.
        expect_frame(24'h021122, 3, 2);
        feed(16'h0211, 2);
        enable = 1'b1;
        wait_valid("t4", 40);
        tick(1);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge rd_clk);
            check("t4_no_rd_en", {31'd0, bus.rd_en}, 32'd0);
        end
        check("t4_busy_held", {31'd0, busy}, 32'd1);
        tick(1);
        feed(8'h22, 1);
        wait_last("t4", 40);
        check("t4_last_data", {24'd0, bus.m_data}, 32'h22);
        tick(3);

        // Abort in the cycle after the pop for payload byte 2.
        push_frame(40'h04B1B2B3B4, 5, 1);
        enable = 1'b1;
        n = 0;
        for (int i = 0; i < 40 && n < 3; i++) begin
            @(negedge rd_clk);
            if (bus.rd_en) n++;
        end
        check("t5_pops_seen", n, 32'd3);
        @(posedge rd_clk);
        #1;
        abort  = 1'b1;
        enable = 1'b0;
        @(negedge rd_clk);
        check("t5_rd_en_in_abort", {31'd0, bus.rd_en}, 32'd0);
        @(posedge rd_clk);
        #1;
        abort = 1'b0;
        @(negedge rd_clk);
        check("t5_m_valid", {31'd0, bus.m_valid}, 32'd0);
        check("t5_busy",    {31'd0, busy},        32'd0);
        check("t5_m_last",  {31'd0, bus.m_last},  32'd0);
        flush_req = 1'b1;
        tick(1);
        flush_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge rd_clk);
            check("t5_quiet", {31'd0, bus.m_valid}, 32'd0);
        end
        tick(1);

        // Async reset while a byte is stalled on the stream.
        push_frame(32'h03C1C2C3, 4, 0);
        bus.m_ready = 1'b0;
        enable = 1'b1;
        wait_valid("t6", 40);
        check("t6_pre_data", {24'd0, bus.m_data}, 32'hC1);
        @(posedge rd_clk);
        #1;
        enable = 1'b0;
        rrst_n = 1'b0;
        #1;
        check_reset_outputs("t6");
        repeat (2) @(posedge rd_clk);
        #1;
        rrst_n = 1'b1;
        flush_req = 1'b1;
        tick(1);
        flush_req = 1'b0;
        tick(3);
        check("t6_idle_after", {31'd0, busy}, 32'd0);

        check("model_queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
